// File: rtl/playback_timer.sv
// playback_timer: BCD mm:ss elapsed/remaining-time counter driven by a clk-cycle prescaler.
// Ports: clk, reset (async, active-high); count/clear/dir/load controls; load_minutes/
//   load_seconds1/load_seconds0 BCD preset; seconds0/seconds1/minutes BCD time;
//   sec_tick one-cycle pulse per prescaler wrap; at_limit level (MAX going up, 0 going down).
// Optional feature: define PLAYBACK_TIMER_ALARM_EN to add alarm_minutes/alarm_seconds1/
//   alarm_seconds0 inputs and the one-cycle alarm output.
module playback_timer #(
  parameter int CLK_DIV    = 50000000,
  parameter int MIN_DIGITS = 2,
  parameter int WRAP       = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    count,
  input  logic                    clear,
  input  logic                    dir,
  input  logic                    load,
  input  logic [4*MIN_DIGITS-1:0] load_minutes,
  input  logic [3:0]              load_seconds1,
  input  logic [3:0]              load_seconds0,
  output logic [3:0]              seconds0,
  output logic [3:0]              seconds1,
  output logic [4*MIN_DIGITS-1:0] minutes,
  output logic                    sec_tick,
  output logic                    at_limit
`ifdef PLAYBACK_TIMER_ALARM_EN
  ,
  input  logic [4*MIN_DIGITS-1:0] alarm_minutes,
  input  logic [3:0]              alarm_seconds1,
  input  logic [3:0]              alarm_seconds0,
  output logic                    alarm
`endif
);

  localparam int MW = 4 * MIN_DIGITS;
  localparam int PW = $clog2(CLK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);
  localparam logic [MW-1:0] MIN_ALL9 = {MIN_DIGITS{4'h9}};

  logic [PW-1:0] presc;
  logic          terminal;
  logic          is_max;
  logic          is_zero;
  logic          carry;
  logic          borrow;
  logic [3:0]    up_s0, up_s1, dn_s0, dn_s1, nx_s0, nx_s1, ld_s0, ld_s1;
  logic [MW-1:0] up_min, dn_min, nx_min, ld_min;

  function automatic logic [3:0] clamp(input logic [3:0] d, input logic [3:0] lim);
    return (d > lim) ? lim : d;
  endfunction

  // The prescaler only wraps while counting, so a frozen timer never ticks.
  assign terminal = count && (presc == PRE_LAST);

  assign is_max   = (minutes == MIN_ALL9) && (seconds1 == 4'd5) && (seconds0 == 4'd9);
  assign is_zero  = (minutes == '0) && (seconds1 == 4'd0) && (seconds0 == 4'd0);
  assign at_limit = dir ? is_zero : is_max;

  // Increment: the ripple from MAX naturally lands on all zeros.
  always_comb begin
    up_s0  = seconds0 + 4'd1;
    up_s1  = seconds1;
    up_min = minutes;
    carry  = 1'b0;
    if (seconds0 == 4'd9) begin
      up_s0 = 4'd0;
      if (seconds1 == 4'd5) begin
        up_s1 = 4'd0;
        carry = 1'b1;
      end else begin
        up_s1 = seconds1 + 4'd1;
      end
    end
    for (int i = 0; i < MIN_DIGITS; i++) begin
      if (carry) begin
        if (minutes[4*i +: 4] == 4'd9) begin
          up_min[4*i +: 4] = 4'd0;
        end else begin
          up_min[4*i +: 4] = minutes[4*i +: 4] + 4'd1;
          carry            = 1'b0;
        end
      end
    end
  end

  // Decrement: the borrow ripple from zero naturally lands on MAX.
  always_comb begin
    dn_s0  = seconds0 - 4'd1;
    dn_s1  = seconds1;
    dn_min = minutes;
    borrow = 1'b0;
    if (seconds0 == 4'd0) begin
      dn_s0 = 4'd9;
      if (seconds1 == 4'd0) begin
        dn_s1  = 4'd5;
        borrow = 1'b1;
      end else begin
        dn_s1 = seconds1 - 4'd1;
      end
    end
    for (int i = 0; i < MIN_DIGITS; i++) begin
      if (borrow) begin
        if (minutes[4*i +: 4] == 4'd0) begin
          dn_min[4*i +: 4] = 4'd9;
        end else begin
          dn_min[4*i +: 4] = minutes[4*i +: 4] - 4'd1;
          borrow           = 1'b0;
        end
      end
    end
  end

  // Next time on a tick; saturating builds hold when already at the limit for this direction.
  always_comb begin
    nx_s0  = dir ? dn_s0  : up_s0;
    nx_s1  = dir ? dn_s1  : up_s1;
    nx_min = dir ? dn_min : up_min;
    if (at_limit && (WRAP == 0)) begin
      nx_s0  = seconds0;
      nx_s1  = seconds1;
      nx_min = minutes;
    end
  end

  always_comb begin
    ld_s0  = clamp(load_seconds0, 4'd9);
    ld_s1  = clamp(load_seconds1, 4'd5);
    ld_min = '0;
    for (int i = 0; i < MIN_DIGITS; i++) begin
      ld_min[4*i +: 4] = clamp(load_minutes[4*i +: 4], 4'd9);
    end
  end

  // sec_tick follows the prescaler wrap even when clear/load override the time update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc    <= '0;
      seconds0 <= 4'd0;
      seconds1 <= 4'd0;
      minutes  <= '0;
      sec_tick <= 1'b0;
    end else begin
      sec_tick <= terminal;
      if (clear) begin
        presc    <= '0;
        seconds0 <= 4'd0;
        seconds1 <= 4'd0;
        minutes  <= '0;
      end else if (load) begin
        presc    <= '0;
        seconds0 <= ld_s0;
        seconds1 <= ld_s1;
        minutes  <= ld_min;
      end else begin
        if (count) begin
          presc <= terminal ? '0 : presc + PW'(1);
        end
        if (terminal) begin
          seconds0 <= nx_s0;
          seconds1 <= nx_s1;
          minutes  <= nx_min;
        end
      end
    end
  end

`ifdef PLAYBACK_TIMER_ALARM_EN
  logic alarm_hit;

  // Only a tick that actually moves the time onto the alarm value counts; holding at a
  // saturated limit equal to the alarm does not re-fire.
  assign alarm_hit = ({nx_min, nx_s1, nx_s0} == {alarm_minutes, alarm_seconds1, alarm_seconds0}) &&
                     ({nx_min, nx_s1, nx_s0} != {minutes, seconds1, seconds0});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alarm <= 1'b0;
    end else begin
      alarm <= terminal && !clear && !load && alarm_hit;
    end
  end
`endif

endmodule

// File: tb/tb_playback_timer.sv
// tb_playback_timer: randomized and directed checks of playback_timer against a
// seconds-based reference model; two instances (WRAP=1 and WRAP=0) share all inputs.
// Optional: define PLAYBACK_TIMER_ALARM_EN to exercise the alarm output as well.
module tb_playback_timer;

  localparam int CD   = 4;
  localparam int TMAX = 99 * 60 + 59;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic       count = 1'b0;
  logic       clear = 1'b0;
  logic       dir   = 1'b0;
  logic       load  = 1'b0;
  logic [7:0] load_minutes  = 8'h00;
  logic [3:0] load_seconds1 = 4'd0;
  logic [3:0] load_seconds0 = 4'd0;
  logic [7:0] alarm_minutes  = 8'h00;
  logic [3:0] alarm_seconds1 = 4'd0;
  logic [3:0] alarm_seconds0 = 4'd3;

  logic [3:0] s0_a, s1_a, s0_b, s1_b;
  logic [7:0] min_a, min_b;
  logic       tick_a, tick_b, lim_a, lim_b;
`ifdef PLAYBACK_TIMER_ALARM_EN
  logic       alarm_a, alarm_b;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: time kept as a plain count of seconds.
  int pre_m    = 0;
  int t_w1     = 0;
  int t_w0     = 0;
  bit tick_m   = 1'b0;
  bit alarm_m1 = 1'b0;
  bit alarm_m0 = 1'b0;

  playback_timer #(.CLK_DIV(CD), .MIN_DIGITS(2), .WRAP(1)) dut_wrap (
    .clk(clk), .reset(reset), .count(count), .clear(clear), .dir(dir), .load(load),
    .load_minutes(load_minutes), .load_seconds1(load_seconds1), .load_seconds0(load_seconds0),
    .seconds0(s0_a), .seconds1(s1_a), .minutes(min_a), .sec_tick(tick_a), .at_limit(lim_a)
`ifdef PLAYBACK_TIMER_ALARM_EN
    , .alarm_minutes(alarm_minutes), .alarm_seconds1(alarm_seconds1),
    .alarm_seconds0(alarm_seconds0), .alarm(alarm_a)
`endif
  );

  playback_timer #(.CLK_DIV(CD), .MIN_DIGITS(2), .WRAP(0)) dut_sat (
    .clk(clk), .reset(reset), .count(count), .clear(clear), .dir(dir), .load(load),
    .load_minutes(load_minutes), .load_seconds1(load_seconds1), .load_seconds0(load_seconds0),
    .seconds0(s0_b), .seconds1(s1_b), .minutes(min_b), .sec_tick(tick_b), .at_limit(lim_b)
`ifdef PLAYBACK_TIMER_ALARM_EN
    , .alarm_minutes(alarm_minutes), .alarm_seconds1(alarm_seconds1),
    .alarm_seconds0(alarm_seconds0), .alarm(alarm_b)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int step(input int t, input bit down, input bit wrap);
    if (!down) return (t == TMAX) ? (wrap ? 0 : TMAX) : t + 1;
    return (t == 0) ? (wrap ? TMAX : 0) : t - 1;
  endfunction

  function automatic int bcd2(input logic [3:0] hi, input logic [3:0] lo);
    return int'(hi) * 10 + int'(lo);
  endfunction

  function automatic logic [3:0] lim(input logic [3:0] d, input logic [3:0] m);
    return (d > m) ? m : d;
  endfunction

  function automatic int load_val();
    int mm;
    int ss;
    mm = bcd2(lim(load_minutes[7:4], 4'd9), lim(load_minutes[3:0], 4'd9));
    ss = bcd2(lim(load_seconds1, 4'd5), lim(load_seconds0, 4'd9));
    return mm * 60 + ss;
  endfunction

  function automatic int alarm_t();
    return bcd2(alarm_minutes[7:4], alarm_minutes[3:0]) * 60 + bcd2(alarm_seconds1, alarm_seconds0);
  endfunction

  function automatic logic [15:0] digits(input int t);
    int mm;
    int ss;
    mm = t / 60;
    ss = t % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  task automatic model_reset();
    pre_m = 0; t_w1 = 0; t_w0 = 0;
    tick_m = 1'b0; alarm_m1 = 1'b0; alarm_m0 = 1'b0;
  endtask

  task automatic model_edge();
    bit term;
    int n1;
    int n0;
    term   = count && (pre_m == CD - 1);
    tick_m = term;
    n1 = t_w1;
    n0 = t_w0;
    if (clear) begin
      n1 = 0; n0 = 0; pre_m = 0;
    end else if (load) begin
      n1 = load_val(); n0 = n1; pre_m = 0;
    end else begin
      if (count) pre_m = term ? 0 : pre_m + 1;
      if (term) begin
        n1 = step(t_w1, dir, 1'b1);
        n0 = step(t_w0, dir, 1'b0);
      end
    end
    alarm_m1 = term && !clear && !load && (n1 != t_w1) && (n1 == alarm_t());
    alarm_m0 = term && !clear && !load && (n0 != t_w0) && (n0 == alarm_t());
    t_w1 = n1;
    t_w0 = n0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".time_wrap"}, {16'h0, min_a, s1_a, s0_a}, {16'h0, digits(t_w1)});
    check({tag, ".time_sat"},  {16'h0, min_b, s1_b, s0_b}, {16'h0, digits(t_w0)});
    check({tag, ".tick_wrap"}, {31'h0, tick_a}, {31'h0, tick_m});
    check({tag, ".tick_sat"},  {31'h0, tick_b}, {31'h0, tick_m});
    check({tag, ".lim_wrap"},  {31'h0, lim_a}, {31'h0, dir ? (t_w1 == 0) : (t_w1 == TMAX)});
    check({tag, ".lim_sat"},   {31'h0, lim_b}, {31'h0, dir ? (t_w0 == 0) : (t_w0 == TMAX)});
`ifdef PLAYBACK_TIMER_ALARM_EN
    check({tag, ".alarm_wrap"}, {31'h0, alarm_a}, {31'h0, alarm_m1});
    check({tag, ".alarm_sat"},  {31'h0, alarm_b}, {31'h0, alarm_m0});
`endif
  endtask

  // One clock: model follows the edge, DUT sampled 2 time units later.
  task automatic cyc();
    @(posedge clk);
    if (reset) model_reset();
    else model_edge();
    #2;
    check_all("cyc");
  endtask

  task automatic load_time(input logic [7:0] m, input logic [3:0] a, input logic [3:0] b);
    load = 1'b1; load_minutes = m; load_seconds1 = a; load_seconds0 = b;
    cyc();
    load = 1'b0;
  endtask

  task automatic wait_tick(input string tag);
    int n;
    n = 0;
    do begin
      cyc();
      n++;
    end while (!tick_a && n < 20);
    if (!tick_a) check({tag, ".timeout"}, {31'h0, tick_a}, 32'd1);
  endtask

  int nt;
  int last;
  int np;
  int lat;

  initial begin
    // Asynchronous reset before any clock edge.
    #1 reset = 1'b1;
    #1 check_all("reset");
    dir = 1'b1;
    #1 check("reset_lim_dn_wrap", {31'h0, lim_a}, 32'd1);
    check("reset_lim_dn_sat", {31'h0, lim_b}, 32'd1);
    dir = 1'b0;
    #1 check("reset_lim_up", {31'h0, lim_a}, 32'd0);
    cyc();
    reset = 1'b0;
    count = 1'b1;

    // 40 counting cycles: ten ticks, four cycles apart, ending at 00:10.
    nt = 0;
    last = -1;
    for (int c = 0; c < 40; c++) begin
      cyc();
      if (tick_a) begin
        if (last >= 0) check("tick_gap", c - last, CD);
        nt++;
        last = c;
      end
    end
    check("tick_count", nt, 10);
    check("time_00_10", {16'h0, min_a, s1_a, s0_a}, 32'h0010);

    // Carry and limit behaviour counting up.
    load_time(8'h00, 4'd5, 4'd9);
    wait_tick("carry");
    check("up_0059", {16'h0, min_a, s1_a, s0_a}, 32'h0100);
    load_time(8'h99, 4'd5, 4'd9);
    check("lim_at_max", {31'h0, lim_b}, 32'd1);
    wait_tick("max");
    check("wrap_max", {16'h0, min_a, s1_a, s0_a}, 32'h0000);
    check("sat_max", {16'h0, min_b, s1_b, s0_b}, 32'h9959);
    check("sat_max_lim", {31'h0, lim_b}, 32'd1);

    // Borrow and limit behaviour counting down.
    dir = 1'b1;
    load_time(8'h01, 4'd0, 4'd0);
    wait_tick("borrow");
    check("dn_0100", {16'h0, min_a, s1_a, s0_a}, 32'h0059);
    load_time(8'h00, 4'd0, 4'd0);
    wait_tick("zero");
    check("wrap_zero", {16'h0, min_a, s1_a, s0_a}, 32'h9959);
    check("sat_zero", {16'h0, min_b, s1_b, s0_b}, 32'h0000);
    check("sat_zero_lim", {31'h0, lim_b}, 32'd1);

    // Load clamping and clear-over-load priority.
    count = 1'b0;
    dir = 1'b0;
    load_time(8'h00, 4'd7, 4'd12);
    check("clamp_sec", {16'h0, min_a, s1_a, s0_a}, 32'h0059);
    load_time(8'hC5, 4'd3, 4'd2);
    check("clamp_min", {16'h0, min_a, s1_a, s0_a}, 32'h9532);
    clear = 1'b1;
    load_time(8'h12, 4'd3, 4'd4);
    clear = 1'b0;
    check("clear_over_load", {16'h0, min_a, s1_a, s0_a}, 32'h0000);

    // Reset mid-prescale takes effect before the next clock edge.
    load_time(8'h00, 4'd4, 4'd2);
    count = 1'b1;
    cyc();
    cyc();
    #1 reset = 1'b1;
    model_reset();
    #1 check_all("async_rst");
    cyc();
    reset = 1'b0;
    lat = 0;
    do begin
      cyc();
      lat++;
    end while (!tick_a && lat < 20);
    check("rst_tick_lat", lat, CD);

`ifdef PLAYBACK_TIMER_ALARM_EN
    // Alarm at 00:03 fires once on the tick that reaches it, never on a load.
    dir = 1'b0;
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    np = 0;
    for (int c = 0; c < 20; c++) begin
      cyc();
      if (alarm_a) begin
        np++;
        check("alarm_with_tick", {31'h0, tick_a}, 32'd1);
        check("alarm_time", {16'h0, min_a, s1_a, s0_a}, 32'h0003);
      end
    end
    check("alarm_pulses", np, 1);
    count = 1'b0;
    np = 0;
    load_time(8'h00, 4'd0, 4'd3);
    if (alarm_a) np++;
    for (int c = 0; c < 6; c++) begin
      cyc();
      if (alarm_a) np++;
    end
    check("alarm_on_load", np, 0);
`endif

    // Randomized control traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      count = ($urandom % 8) != 0;
      if (($urandom % 64) == 0) dir = ~dir;
      clear = ($urandom % 300) == 0;
      load  = ($urandom % 30) == 0;
      case ($urandom % 4)
        0: begin
          load_minutes = 8'h99; load_seconds1 = 4'd5;
          load_seconds0 = 4'($urandom_range(5, 15));
        end
        1: begin
          load_minutes = 8'h00; load_seconds1 = 4'd0;
          load_seconds0 = 4'($urandom_range(0, 3));
        end
        2: begin
          load_minutes = 8'($urandom); load_seconds1 = 4'($urandom);
          load_seconds0 = 4'($urandom);
        end
        default: begin
          load_minutes = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
          load_seconds1 = 4'($urandom_range(0, 5));
          load_seconds0 = 4'($urandom_range(0, 9));
        end
      endcase
      cyc();
    end
    clear = 1'b0;
    load  = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/playback_timer.md
PLAYBACK_TIMER -- requirements
Module: playback_timer

Interface
REQ-001 Parameter CLK_DIV, default 50000000: clk cycles per elapsed second, legal range 2 and above.
REQ-002 Parameter MIN_DIGITS, default 2: number of BCD minute digits, legal range 1 to 3.
REQ-003 Parameter WRAP, default 1: 1 means wrap at the count limit, 0 means saturate at it.
REQ-004 clk  in  1  single system clock; all state changes on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 count  in  1  run enable; 1 means advance time, 0 means freeze time and prescaler.
REQ-007 clear  in  1  synchronous clear of time and prescaler.
REQ-008 dir  in  1  0 means count up (elapsed time), 1 means count down (remaining time).
REQ-009 load  in  1  synchronous load of the load_* values.
REQ-010 load_minutes  in  4*MIN_DIGITS  BCD minutes to load, most significant digit at the top.
REQ-011 load_seconds1, load_seconds0  in  4 each  BCD tens and units of seconds to load.
REQ-012 seconds0  out  4  BCD units of seconds, range 0-9.
REQ-013 seconds1  out  4  BCD tens of seconds, range 0-5.
REQ-014 minutes  out  4*MIN_DIGITS  BCD minutes, each digit in range 0-9.
REQ-015 sec_tick  out  1  one-cycle pulse at every prescaler terminal count.
REQ-016 at_limit  out  1  level output: high when dir=0 and time=MAX, or when dir=1 and time=0.

Function
REQ-017 The design SHALL be fully synchronous to clk; no derived clocks and no digit-carry clocking.
REQ-018 Prescaler SHALL count 0 to CLK_DIV-1 while count=1, hold while count=0, and return to 0 after CLK_DIV-1.
REQ-019 sec_tick SHALL be registered and high for exactly the cycle following the prescaler's CLK_DIV-1 edge; time digits SHALL update on that same edge.
REQ-020 Per sec_tick, dir=0: seconds0 increments; 9->0 carries into seconds1; seconds1 5->0 carries into minutes; minutes follow a BCD ripple.
REQ-021 Per sec_tick, dir=1: seconds0 decrements; 0->9 borrows from seconds1; seconds1 0->5 borrows from minutes; minutes follow a BCD ripple borrow.
REQ-022 MAX is defined as all minute digits 9, seconds1=5, seconds0=9.
REQ-023 A tick at MAX going up, with WRAP=1, SHALL yield 0:00; with WRAP=0, time SHALL hold at MAX.
REQ-024 A tick at 0 going down, with WRAP=1, SHALL yield MAX; with WRAP=0, time SHALL hold at 0.
REQ-025 Load SHALL clamp out-of-range digits: seconds0 and minute digits above 9 become 9; seconds1 above 5 becomes 5.
REQ-026 Load SHALL also zero the prescaler.
REQ-027 Same-edge priority SHALL be: reset > clear > load > tick.
REQ-028 When clear or load wins, a coincident tick is lost; sec_tick is still emitted.
REQ-029 A dir change SHALL take effect on the next tick with no glitch in the digits.
REQ-030 at_limit SHALL be combinational from the registered digits and dir.

Reset
REQ-031 reset=1 SHALL immediately force seconds0, seconds1, minutes, prescaler and sec_tick to 0, independent of clk.
REQ-032 at_limit SHALL read 0 during reset when dir=0, and 1 during reset when dir=1.
REQ-033 After reset deasserts, the first tick SHALL occur CLK_DIV cycles after the first edge with count=1.

Configuration
REQ-034 Macro PLAYBACK_TIMER_ALARM_EN, when defined, SHALL add inputs alarm_minutes (4*MIN_DIGITS bits), alarm_seconds1 (4 bits) and alarm_seconds0 (4 bits), plus output alarm (1 bit).
REQ-035 With PLAYBACK_TIMER_ALARM_EN defined, alarm SHALL pulse high for one cycle, aligned with sec_tick, when a tick changes time into equality with the alarm value; equality reached by load or clear SHALL NOT raise alarm; alarm resets to 0.
REQ-036 Without PLAYBACK_TIMER_ALARM_EN, the alarm ports and comparator SHALL be absent and all other behaviour SHALL be unchanged.

Verification (CLK_DIV=4, MIN_DIGITS=2)
REQ-037 Reset, then count=1 and dir=0 for 40 cycles -> 10 sec_tick pulses, time 00:10, and each sec_tick exactly 4 cycles apart.
REQ-038 Load 00:59, then tick up -> 01:00; load 99:59 with WRAP=1, then tick -> 00:00; same with WRAP=0 -> holds 99:59 and at_limit=1.
REQ-039 dir=1, load 01:00, then tick -> 00:59; at 00:00 with WRAP=0, ticking -> holds and at_limit=1; with WRAP=1 -> 99:59.
REQ-040 Load with seconds0=12 and seconds1=7 -> reads 00:59; clear asserted with load on the same edge -> 00:00.
REQ-041 Assert reset mid-prescale with count=1 -> outputs 0 within the same cycle, before any clk edge; next tick 4 cycles after release.
REQ-042 With the macro defined and alarm=00:03, count up from 00:00 -> alarm pulses once, with sec_tick, at 00:03; loading 00:03 -> no alarm pulse.
